// File: rtl/angle_frame_packer.sv
// Captures roll/pitch from the shared angle bus and streams each complete pair
// as a byte frame to the UART TX. Optional checksum byte: ANGLE_PACK_CHKSUM_EN.
module angle_frame_packer #(
  parameter logic [7:0] HEADER0 = 8'h55,
  parameter logic [7:0] HEADER1 = 8'hAA
) (
  input  logic        clk_in,
  input  logic        rst_n,
  input  logic        calib_done_in,
  input  logic [31:0] angle_opt_in,
  input  logic        roll_opt_vld_in,
  input  logic        pitch_opt_vld_in,
  input  logic        tx_ready_in,
  output logic [7:0]  tx_data_out,
  output logic        tx_valid_out,
  output logic        frame_busy_out,
  output logic [7:0]  ovf_cnt_out
);

`ifdef ANGLE_PACK_CHKSUM_EN
  typedef enum logic [1:0] {IDLE, HEAD, DATA, SUM} state_t;
`else
  typedef enum logic [1:0] {IDLE, HEAD, DATA} state_t;
`endif

  state_t      state_q;
  logic [31:0] roll_q, roll_d, pitch_q, pitch_d;
  logic        roll_new_q, roll_new_d, pitch_new_q, pitch_new_d;
  logic [7:0]  ovf_q, ovf_d;
  logic [31:0] snap_roll_q, snap_pitch_q;
  logic [2:0]  idx_q;
  logic [7:0]  tx_data_q;
  logic        tx_valid_q;
`ifdef ANGLE_PACK_CHKSUM_EN
  logic [7:0]  sum_q;
`endif

  logic        start, xfer, ovf_hit;
  logic [63:0] snap_w;
  logic [2:0]  idx_nx;
  logic [7:0]  next_data_byte;

  assign start  = (state_q == IDLE) & roll_new_q & pitch_new_q & calib_done_in;
  assign xfer   = tx_valid_q & tx_ready_in;
  assign snap_w = {snap_roll_q, snap_pitch_q};
  assign idx_nx = idx_q + 3'd1;
  assign next_data_byte = snap_w[{3'd7 - idx_nx, 3'b000} +: 8];

  // Capture path; a capture landing on the start cycle re-arms its flag without
  // counting as an overwrite, since the old value was just snapshotted.
  always_comb begin
    roll_d      = roll_q;
    pitch_d     = pitch_q;
    roll_new_d  = roll_new_q;
    pitch_new_d = pitch_new_q;
    ovf_d       = ovf_q;
    ovf_hit     = 1'b0;
    if (!calib_done_in) begin
      roll_new_d  = 1'b0;
      pitch_new_d = 1'b0;
    end else begin
      if (start) begin
        roll_new_d  = 1'b0;
        pitch_new_d = 1'b0;
      end
      if (roll_opt_vld_in) begin
        roll_d     = angle_opt_in;
        roll_new_d = 1'b1;
        ovf_hit    = roll_new_q & ~start;
      end else if (pitch_opt_vld_in) begin
        pitch_d     = angle_opt_in;
        pitch_new_d = 1'b1;
        ovf_hit     = pitch_new_q & ~start;
      end
      if (ovf_hit && ovf_q != 8'hFF) ovf_d = ovf_q + 8'd1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      roll_q      <= '0;
      pitch_q     <= '0;
      roll_new_q  <= 1'b0;
      pitch_new_q <= 1'b0;
      ovf_q       <= '0;
    end else begin
      roll_q      <= roll_d;
      pitch_q     <= pitch_d;
      roll_new_q  <= roll_new_d;
      pitch_new_q <= pitch_new_d;
      ovf_q       <= ovf_d;
    end
  end

  // tx_data_q always holds the byte currently offered; it advances only on xfer.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      snap_roll_q  <= '0;
      snap_pitch_q <= '0;
      idx_q        <= '0;
      tx_data_q    <= '0;
      tx_valid_q   <= 1'b0;
`ifdef ANGLE_PACK_CHKSUM_EN
      sum_q        <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q      <= HEAD;
            snap_roll_q  <= roll_q;
            snap_pitch_q <= pitch_q;
            idx_q        <= '0;
            tx_data_q    <= HEADER0;
            tx_valid_q   <= 1'b1;
`ifdef ANGLE_PACK_CHKSUM_EN
            sum_q        <= '0;
`endif
          end
        end
        HEAD: begin
          if (xfer) begin
            if (idx_q == 3'd0) begin
              idx_q     <= 3'd1;
              tx_data_q <= HEADER1;
            end else begin
              state_q   <= DATA;
              idx_q     <= '0;
              tx_data_q <= snap_w[63:56];
            end
          end
        end
        DATA: begin
          if (xfer) begin
`ifdef ANGLE_PACK_CHKSUM_EN
            sum_q <= sum_q + tx_data_q;
`endif
            if (idx_q == 3'd7) begin
`ifdef ANGLE_PACK_CHKSUM_EN
              state_q   <= SUM;
              tx_data_q <= sum_q + tx_data_q;
`else
              state_q    <= IDLE;
              tx_data_q  <= '0;
              tx_valid_q <= 1'b0;
`endif
            end else begin
              idx_q     <= idx_nx;
              tx_data_q <= next_data_byte;
            end
          end
        end
`ifdef ANGLE_PACK_CHKSUM_EN
        SUM: begin
          if (xfer) begin
            state_q    <= IDLE;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
          end
        end
`endif
        default: begin
          state_q    <= IDLE;
          tx_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign tx_data_out    = tx_data_q;
  assign tx_valid_out   = tx_valid_q;
  assign frame_busy_out = (state_q != IDLE);
  assign ovf_cnt_out    = ovf_q;

endmodule

// File: tb/tb_angle_frame_packer.sv
// Directed bench for angle_frame_packer: frame vectors table plus corner sequences.
module tb_angle_frame_packer;
`ifdef ANGLE_PACK_CHKSUM_EN
  localparam int FLEN = 11;
`else
  localparam int FLEN = 10;
`endif

  logic        clk, rst_n, calib, roll_vld, pitch_vld, tx_ready;
  logic [31:0] angle;
  logic [7:0]  tx_data, ovf;
  logic        tx_valid, busy;

  angle_frame_packer dut (
    .clk_in(clk), .rst_n(rst_n), .calib_done_in(calib),
    .angle_opt_in(angle), .roll_opt_vld_in(roll_vld), .pitch_opt_vld_in(pitch_vld),
    .tx_ready_in(tx_ready), .tx_data_out(tx_data), .tx_valid_out(tx_valid),
    .frame_busy_out(busy), .ovf_cnt_out(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0]        roll;
    logic [31:0]        pitch;
    bit                 tog;
    logic [0:10][7:0]   exp;
  } vec_t;

  logic [7:0] got [0:15];
  int gotn, span;

  task automatic do_reset();
    tx_ready = 1'b1; roll_vld = 1'b0; pitch_vld = 1'b0; angle = '0; calib = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_valid", tx_valid, 0);
    chk("rst_data", tx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", ovf, 0);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Called at a negedge; strobe is sampled at the following posedge.
  task automatic strobe(input bit r, input bit p, input logic [31:0] a);
    roll_vld = r; pitch_vld = p; angle = a;
    @(negedge clk);
    roll_vld = 1'b0; pitch_vld = 1'b0;
  endtask

  task automatic collect(input int n, input bit tog, input int budget);
    int c; bit started, pv, pr; logic [7:0] pd;
    gotn = 0; c = 0; started = 0; pv = 0; pr = 1; pd = '0; span = 0;
    while (gotn < n && c < budget) begin
      if (pv && !pr) begin
        chk("hold_valid", tx_valid, 1);
        chk("hold_data", tx_data, pd);
      end
      tx_ready = tog ? (c % 3 == 0) : 1'b1;
      if (tx_valid) started = 1;
      if (started) span++;
      if (tx_valid && tx_ready) begin
        got[gotn] = tx_data;
        gotn++;
      end
      pv = tx_valid; pd = tx_data; pr = tx_ready;
      c++;
      @(negedge clk);
    end
    tx_ready = 1'b1;
    chk("collect_count", gotn, n);
  endtask

  task automatic check_frame(input string name, input logic [0:10][7:0] exp);
    for (int i = 0; i < FLEN; i++) chk(name, got[i], exp[i]);
  endtask

  task automatic expect_header();
    chk("lat_t1_valid", tx_valid, 0);
    @(negedge clk);
    chk("lat_t2_valid", tx_valid, 1);
    chk("lat_t2_hdr0", tx_data, 8'h55);
  endtask

  vec_t vecs [4];
  logic [0:10][7:0] e2;

  initial begin
    vecs[0] = '{32'h0000_1234, 32'hFFFF_FF00, 1'b0,
                {8'h55, 8'hAA, 8'h00, 8'h00, 8'h12, 8'h34, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h43}};
    vecs[1] = '{32'h0000_1234, 32'hFFFF_FF00, 1'b1,
                {8'h55, 8'hAA, 8'h00, 8'h00, 8'h12, 8'h34, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h43}};
    vecs[2] = '{32'h8000_0001, 32'h7F7F_0102, 1'b0,
                {8'h55, 8'hAA, 8'h80, 8'h00, 8'h00, 8'h01, 8'h7F, 8'h7F, 8'h01, 8'h02, 8'h82}};
    vecs[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1,
                {8'h55, 8'hAA, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hF8}};

    rst_n = 1'b0; calib = 1'b1; tx_ready = 1'b1;
    roll_vld = 1'b0; pitch_vld = 1'b0; angle = '0;

    for (int v = 0; v < 4; v++) begin
      do_reset();
      strobe(1, 0, vecs[v].roll);
      strobe(0, 1, vecs[v].pitch);
      expect_header();
      collect(FLEN, vecs[v].tog, 100);
      check_frame("vec_byte", vecs[v].exp);
      if (!vecs[v].tog) chk("consecutive_span", span, FLEN);
      chk("end_valid", tx_valid, 0);
      chk("end_busy", busy, 0);
    end

    // Captures during a frame: old snapshot goes out, new pair follows after one idle cycle.
    do_reset();
    strobe(1, 0, 32'h0000_1234);
    strobe(0, 1, 32'hFFFF_FF00);
    expect_header();
    tx_ready = 1'b0;
    strobe(1, 0, 32'h1);
    strobe(1, 0, 32'h1);
    strobe(0, 1, 32'h2);
    chk("midframe_hold_hdr0", tx_data, 8'h55);
    collect(FLEN, 0, 100);
    check_frame("old_snap", vecs[0].exp);
    chk("ovf_one", ovf, 1);
    chk("b2b_idle", tx_valid, 0);
    @(negedge clk);
    chk("b2b_valid", tx_valid, 1);
    chk("b2b_hdr0", tx_data, 8'h55);
    collect(FLEN, 0, 100);
    e2 = {8'h55, 8'hAA, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h03};
    check_frame("new_snap", e2);

    // Simultaneous strobes: roll wins, pitch ignored, no frame.
    do_reset();
    strobe(1, 1, 32'h5);
    repeat (3) @(negedge clk);
    chk("simul_no_valid", tx_valid, 0);
    chk("simul_no_busy", busy, 0);
    strobe(0, 1, 32'h7);
    expect_header();
    collect(FLEN, 0, 100);
    e2 = {8'h55, 8'hAA, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h07, 8'h0C};
    check_frame("simul_frame", e2);

    // Calibration gating, then reset abandoning a frame mid-DATA.
    do_reset();
    calib = 1'b0;
    strobe(1, 0, 32'hA);
    strobe(0, 1, 32'hB);
    repeat (4) @(negedge clk);
    chk("nocal_valid", tx_valid, 0);
    calib = 1'b1;
    repeat (3) @(negedge clk);
    chk("flags_cleared_valid", tx_valid, 0);
    strobe(1, 0, 32'h1122_3344);
    strobe(0, 1, 32'h5566_7788);
    expect_header();
    repeat (5) @(negedge clk);
    chk("data_byte3", tx_data, 8'h44);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", tx_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_data", tx_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", tx_valid, 0);
    chk("post_rst_data", tx_data, 0);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_ovf", ovf, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
